hex_entry: RTL and testbench

Downstream consumer of the debounced push-button levels. Turns rising edges on three debounced buttons (digit, delete, enter) plus a 4-bit switch nibble into a hexadecimal word typed digit-by-digit. Presents the completed word to the CPU I/O side with a valid/ack handshake. Sits between the button debouncers and the memory-mapped input port; also drives the live value shown on the 7-segment display.

---
 rtl/hex_entry_pkg.sv | 11 +
 rtl/hex_entry_if.sv | 31 +++
 rtl/hex_entry_rise_det.sv | 19 +
 rtl/hex_entry.sv | 87 ++++++++
 tb/tb_hex_entry.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the hex digit entry block.
package hex_entry_pkg;

    typedef enum logic {
        EDIT = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam int DEF_DIGITS = 8;

endpackage

// File: rtl/hex_entry_if.sv
// Button/switch inputs, CPU handshake and display outputs of hex_entry.
interface hex_entry_if
    import hex_entry_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic [3:0]    sw;
    logic          btn_dig;
    logic          btn_del;
    logic          btn_ent;
    logic          ack;
    logic [W-1:0]  val;
    logic [CW-1:0] dig_cnt;
    logic [W-1:0]  data;
    logic          valid;
    logic          err;

    modport master (
        output sw, btn_dig, btn_del, btn_ent, ack,
        input  val, dig_cnt, data, valid, err
    );

    modport slave (
        input  sw, btn_dig, btn_del, btn_ent, ack,
        output val, dig_cnt, data, valid, err
    );

endinterface

// File: rtl/hex_entry_rise_det.sv
// Rising-edge detector on a debounced level; the history bit resets high so a
// button held through reset must be released before it can register again.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b1;
        else     prev <= lvl;
    end

    assign rise = lvl & ~prev;

endmodule

// File: rtl/hex_entry.sv
// Hex word entry: button edges edit a working value digit by digit and commit
// it to a valid/ack output register for the CPU.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic        clk,
    input  logic        rst,
    hex_entry_if.slave  bus
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic dig_r, del_r, ent_r;

    rise_det u_dig (.clk(clk), .rst(rst), .lvl(bus.btn_dig), .rise(dig_r));
    rise_det u_del (.clk(clk), .rst(rst), .lvl(bus.btn_del), .rise(del_r));
    rise_det u_ent (.clk(clk), .rst(rst), .lvl(bus.btn_ent), .rise(ent_r));

    state_t        state_q, state_d;
    logic [W-1:0]  val_q, val_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_q, data_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EDIT;
            val_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Only the highest-priority edge acts; lower ones in the same cycle vanish.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = 1'b0;

        if (ent_r) begin
            if (state_q == PEND || cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                data_d  = val_q;
                val_d   = '0;
                cnt_d   = '0;
                state_d = PEND;
            end
        end else if (del_r) begin
            if (cnt_q != '0) begin
                val_d = val_q >> 4;
                cnt_d = cnt_q - CW'(1);
            end else begin
                err_d = 1'b1;
            end
        end else if (dig_r) begin
            if (cnt_q < CW'(DIGITS)) begin
                val_d = {val_q[W-5:0], bus.sw};
                cnt_d = cnt_q + CW'(1);
            end else begin
                err_d = 1'b1;
            end
        end

        // ack wins over a same-cycle enter, which was already flagged above.
        if (state_q == PEND && bus.ack) state_d = EDIT;
    end

    assign bus.val     = val_q;
    assign bus.dig_cnt = cnt_q;
    assign bus.data    = data_q;
    assign bus.valid   = (state_q == PEND);
    assign bus.err     = err_q;

endmodule

// File: tb/tb_hex_entry.sv
// Bench for hex_entry: queue-of-digits reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized button phase.
module tb_hex_entry;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hex_entry_if #(.DIGITS(8)) bus ();

    hex_entry #(.DIGITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the word is a list of typed digits, most significant first.
    bit [3:0]    q[$];
    logic [31:0] m_data = '0;
    bit          m_pend = 1'b0;
    bit          m_err  = 1'b0;
    bit          pg = 1'b1, pd = 1'b1, pe = 1'b1;

    function automatic logic [31:0] m_val();
        logic [31:0] v = '0;
        foreach (q[i]) v = (v << 4) | 32'(q[i]);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_data = '0;
            m_pend = 1'b0;
            m_err  = 1'b0;
            pg = 1'b1; pd = 1'b1; pe = 1'b1;
        end else begin
            bit rg, rd, re, ackd;
            rg = bus.btn_dig & ~pg;
            rd = bus.btn_del & ~pd;
            re = bus.btn_ent & ~pe;
            pg = bus.btn_dig; pd = bus.btn_del; pe = bus.btn_ent;
            ackd  = bus.ack && m_pend;
            m_err = 1'b0;
            if (re) begin
                if (m_pend || q.size() == 0) m_err = 1'b1;
                else begin
                    m_data = m_val();
                    m_pend = 1'b1;
                    q.delete();
                end
            end else if (rd) begin
                if (q.size() > 0) void'(q.pop_back());
                else m_err = 1'b1;
            end else if (rg) begin
                if (q.size() < 8) q.push_back(bus.sw);
                else m_err = 1'b1;
            end
            if (ackd) m_pend = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_val",     bus.val,             m_val());
            chk("model_dig_cnt", 32'(bus.dig_cnt),    32'(q.size()));
            chk("model_data",    bus.data,            m_data);
            chk("model_valid",   32'(bus.valid),      32'(m_pend));
            chk("model_err",     32'(bus.err),        32'(m_err));
        end
    end

    task automatic cyc(input bit d, input bit dl, input bit e, input bit a, input logic [3:0] s);
        @(negedge clk);
        bus.btn_dig = d;
        bus.btn_del = dl;
        bus.btn_ent = e;
        bus.ack     = a;
        bus.sw      = s;
    endtask

    task automatic press(input bit d, input bit dl, input bit e, input logic [3:0] s);
        cyc(d, dl, e, 1'b0, s);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, s);
    endtask

    initial begin
        bus.btn_dig = 1'b0; bus.btn_del = 1'b0; bus.btn_ent = 1'b0;
        bus.ack = 1'b0; bus.sw = 4'h0;
        repeat (2) @(negedge clk);
        chk("reset_val",   bus.val, 32'h0);
        chk("reset_cnt",   32'(bus.dig_cnt), 32'd0);
        chk("reset_valid", 32'(bus.valid), 32'd0);
        chk("reset_err",   32'(bus.err), 32'd0);
        rst = 1'b0;

        press(1, 0, 0, 4'h1);
        press(1, 0, 0, 4'h2);
        press(1, 0, 0, 4'h3);
        chk("digits_val", bus.val, 32'h123);
        chk("digits_cnt", 32'(bus.dig_cnt), 32'd3);

        press(0, 1, 0, 4'h0); chk("del1_val", bus.val, 32'h12);
        press(0, 1, 0, 4'h0); chk("del2_val", bus.val, 32'h1);
        press(0, 1, 0, 4'h0); chk("del3_val", bus.val, 32'h0);
        chk("del3_err", 32'(bus.err), 32'd0);
        press(0, 1, 0, 4'h0);
        chk("del4_err", 32'(bus.err), 32'd1);
        chk("del4_cnt", 32'(bus.dig_cnt), 32'd0);
        cyc(0, 0, 0, 0, 4'h0);
        chk("del4_err_drop", 32'(bus.err), 32'd0);

        press(1, 0, 0, 4'hA);
        press(1, 0, 0, 4'hB);
        press(0, 0, 1, 4'h0);
        chk("ent_data",  bus.data, 32'hAB);
        chk("ent_valid", 32'(bus.valid), 32'd1);
        chk("ent_val",   bus.val, 32'h0);
        press(0, 0, 1, 4'h0);
        chk("ent2_err",  32'(bus.err), 32'd1);
        chk("ent2_data", bus.data, 32'hAB);
        cyc(0, 0, 0, 1, 4'h0);
        cyc(0, 0, 0, 0, 4'h0);
        chk("ack_valid", 32'(bus.valid), 32'd0);
        chk("ack_data",  bus.data, 32'hAB);

        repeat (8) press(1, 0, 0, 4'hF);
        chk("full_val", bus.val, 32'hFFFF_FFFF);
        chk("full_cnt", 32'(bus.dig_cnt), 32'd8);
        press(1, 0, 0, 4'hF);
        chk("over_err", 32'(bus.err), 32'd1);
        cyc(0, 0, 0, 0, 4'h0);
        chk("over_err_drop", 32'(bus.err), 32'd0);
        chk("over_val", bus.val, 32'hFFFF_FFFF);

        press(0, 0, 1, 4'h0);
        cyc(0, 0, 0, 1, 4'h0);
        cyc(0, 0, 0, 0, 4'h0);
        press(1, 0, 0, 4'h5);
        press(1, 0, 1, 4'h7);
        chk("same_data",  bus.data, 32'h5);
        chk("same_val",   bus.val, 32'h0);
        chk("same_valid", 32'(bus.valid), 32'd1);
        chk("same_err",   32'(bus.err), 32'd0);
        cyc(0, 0, 0, 1, 4'h0);
        cyc(0, 0, 0, 0, 4'h0);

        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(99) < 35, $urandom_range(99) < 15,
                $urandom_range(99) < 12, $urandom_range(99) < 20,
                4'($urandom_range(15)));
        end
        repeat (3) cyc(0, 0, 0, 0, 4'h0);

        // Commit a word, then hold the digit button through an async reset.
        press(1, 0, 0, 4'h7);
        press(0, 0, 1, 4'h0);
        chk("pre_rst_valid", 32'(bus.valid), 32'd1);
        cyc(1, 0, 0, 0, 4'h3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.valid), 32'd0);
        chk("async_rst_data",  bus.data, 32'h0);
        chk("async_rst_val",   bus.val, 32'h0);
        chk("async_rst_cnt",   32'(bus.dig_cnt), 32'd0);
        cyc(1, 0, 0, 0, 4'h3);
        cyc(1, 0, 0, 0, 4'h3);
        rst = 1'b0;
        repeat (3) cyc(1, 0, 0, 0, 4'h3);
        chk("held_cnt", 32'(bus.dig_cnt), 32'd0);
        chk("held_val", bus.val, 32'h0);
        cyc(0, 0, 0, 0, 4'h3);
        press(1, 0, 0, 4'h9);
        chk("repress_val", bus.val, 32'h9);
        chk("repress_cnt", 32'(bus.dig_cnt), 32'd1);

        repeat (2) cyc(0, 0, 0, 0, 4'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
